// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC frame controller.
package mac_pkg;

  localparam int MUL_LAT = 4;
  localparam int PROD_W  = 8;
  localparam int CYC_W   = $clog2(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Signed adder with overflow detect; clamps on overflow when MAC_SAT_EN is defined.
module mac_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;

  assign raw   = a_i + b_i;
  assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef MAC_SAT_EN
  // Overflow direction follows the shared operand sign.
  always_comb begin
    sum_o = raw;
    if (ovf_o) sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/mac_frame_ctrl.sv
// Feeds a 4-edge-sampling multiplier and accumulates products per frame.
// Build option: MAC_SAT_EN selects a saturating accumulator instead of wrapping.
module mac_frame_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  input  logic              in_last,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [PROD_W-1:0] mul_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               last_q, last_d;
  logic [3:0]         a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   prod_ext, add_sum;
  logic               add_ovf, accept;

  assign prod_ext = ACC_W'($signed(mul_c));

  mac_sat_add #(.W(ACC_W)) u_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  // Ready is a pure state decode so it never loops back through in_valid.
  assign in_ready = (state_q == S_IDLE) || (state_q == S_ACC && !last_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          cyc_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == CYC_W'(MUL_LAT - 1)) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = add_sum;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
        if (last_q) begin
          state_d = S_DONE;
        end else if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          cyc_d   = '0;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule
